// File: rtl/stall_perf_counter.sv
// Stall-cause performance counters: live bank with priority-attributed and raw
// per-flag counts, a snapshot shadow bank, and a one-cycle pipelined read port.
module stall_perf_counter #(
    parameter int NUM_CAUSES = 16,
    parameter int CNT_W      = 32,
    parameter int ADDR_W     = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  count_en,
    input  logic [NUM_CAUSES-1:0] stall_flags,
    input  logic                  dispatch_stall,
    input  logic                  clear,
    input  logic                  snap,
    input  logic                  rd_req,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_ack,
    output logic [CNT_W-1:0]      rd_data,
    output logic                  overflow,
    output logic [1:0]            state_o
);

    localparam int NUM_CNT = 3 + 2 * NUM_CAUSES;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]                      state;
    logic [NUM_CNT-1:0][CNT_W-1:0]   live;
    logic [NUM_CNT-1:0][CNT_W-1:0]   shadow;
    logic [NUM_CNT-1:0]              inc;
    logic                            counted;
    logic                            prim_found;
    logic                            sat_hit;
    logic [CNT_W-1:0]                rd_val;

    assign state_o = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (stop) begin
            if (state == RUN) state <= HOLD;
        end else if (start && state != RUN) begin
            state <= RUN;
        end
    end

    // Primary cause goes to the lowest set flag; only the first hit in the scan claims it.
    always_comb begin
        inc        = '0;
        prim_found = 1'b0;
        counted    = (state == RUN) && count_en;
        if (counted) begin
            inc[0] = 1'b1;
            inc[1] = dispatch_stall;
            inc[2] = dispatch_stall && (stall_flags == '0);
            for (int unsigned i = 0; i < NUM_CAUSES; i++) begin
                inc[3 + NUM_CAUSES + i] = stall_flags[i];
                if (dispatch_stall && stall_flags[i] && !prim_found) begin
                    inc[3 + i] = 1'b1;
                    prim_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sat_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (inc[i] && live[i] == '1) sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live     <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            live     <= '0;
            overflow <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                if (inc[i] && live[i] != '1) live[i] <= live[i] + CNT_W'(1);
            end
            if (sat_hit) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (snap) begin
            shadow <= live;
        end
    end

    // Unmapped addresses fall through to zero.
    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (rd_addr == ADDR_W'(i)) rd_val = shadow[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ack  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_ack <= rd_req;
            if (rd_req) rd_data <= rd_val;
        end
    end

endmodule

// File: tb/tb_stall_perf_counter.sv
// Bench for stall_perf_counter: default build and a 4-bit-counter build driven in
// parallel, checked each cycle against an arithmetic reference model.
module tb_stall_perf_counter;

    localparam int NC = 16;
    localparam int NT = 3 + 2 * NC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, stop = 1'b0, count_en = 1'b0;
    logic [NC-1:0] stall_flags = '0;
    logic          dispatch_stall = 1'b0, clear = 1'b0, snap = 1'b0, rd_req = 1'b0;
    logic [5:0]    rd_addr = '0;
    logic          rd_ack, overflow, rd_ack4, overflow4;
    logic [31:0]   rd_data;
    logic [3:0]    rd_data4;
    logic [1:0]    state_o, state_o4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stall_perf_counter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .count_en(count_en),
        .stall_flags(stall_flags), .dispatch_stall(dispatch_stall), .clear(clear),
        .snap(snap), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data(rd_data), .overflow(overflow), .state_o(state_o)
    );

    stall_perf_counter #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .count_en(count_en),
        .stall_flags(stall_flags), .dispatch_stall(dispatch_stall), .clear(clear),
        .snap(snap), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack4),
        .rd_data(rd_data4), .overflow(overflow4), .state_o(state_o4)
    );

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: index 0 is the 32-bit build, index 1 the 4-bit build.
    longint unsigned m_live [2][NT];
    longint unsigned m_shad [2][NT];
    longint unsigned m_data [2];
    bit              m_ovf  [2];
    bit              m_ack;
    int              m_state;
    bit [NT-1:0]     hits;

    function automatic longint unsigned lim(input int w);
        return (w == 0) ? 64'hFFFF_FFFF : 64'd15;
    endfunction

    function automatic int lowest(input logic [NC-1:0] f);
        int p = 0;
        while (!f[p]) p++;
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < 2; w++) begin
                for (int i = 0; i < NT; i++) begin
                    m_live[w][i] = 0;
                    m_shad[w][i] = 0;
                end
                m_data[w] = 0;
                m_ovf[w]  = 0;
            end
            m_ack   = 0;
            m_state = 0;
        end else begin
            hits = '0;
            if (m_state == 1 && count_en) begin
                hits[0] = 1;
                if (dispatch_stall) begin
                    hits[1] = 1;
                    if (stall_flags == 0) hits[2] = 1;
                    else hits[3 + lowest(stall_flags)] = 1;
                end
                for (int i = 0; i < NC; i++) if (stall_flags[i]) hits[3 + NC + i] = 1;
            end
            m_ack = rd_req;
            for (int w = 0; w < 2; w++) begin
                if (rd_req) m_data[w] = (rd_addr < NT) ? m_shad[w][rd_addr] : 0;
                if (snap) for (int i = 0; i < NT; i++) m_shad[w][i] = m_live[w][i];
                if (clear) begin
                    for (int i = 0; i < NT; i++) m_live[w][i] = 0;
                    m_ovf[w] = 0;
                end else begin
                    for (int i = 0; i < NT; i++) begin
                        if (hits[i]) begin
                            if (m_live[w][i] == lim(w)) m_ovf[w] = 1;
                            else m_live[w][i] = m_live[w][i] + 1;
                        end
                    end
                end
            end
            case (m_state)
                0: if (start && !stop) m_state = 1;
                1: if (stop) m_state = 2;
                2: if (start && !stop) m_state = 1;
                default: m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("state", state_o, m_state);
            chk("state4", state_o4, m_state);
            chk("rd_ack", rd_ack, m_ack);
            chk("rd_ack4", rd_ack4, m_ack);
            chk("rd_data", rd_data, m_data[0]);
            chk("rd_data4", rd_data4, m_data[1]);
            chk("overflow", overflow, m_ovf[0]);
            chk("overflow4", overflow4, m_ovf[1]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a, input longint unsigned exp, input string nm);
        rd_req  = 1'b1;
        rd_addr = 6'(a);
        cyc();
        rd_req = 1'b0;
        chk({nm, "_ack"}, rd_ack, 1);
        chk(nm, rd_data, exp);
    endtask

    task automatic pulse_snap();
        snap = 1'b1;
        cyc();
        snap = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        rst_n = 1'b1;
        chk("rst_state", state_o, 0);
        chk("rst_ack", rd_ack, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_ovf", overflow, 0);

        // Ten plain counted cycles, then back-to-back reads.
        start = 1'b1; cyc(); start = 1'b0;
        count_en = 1'b1;
        repeat (10) cyc();
        count_en = 1'b0;
        pulse_snap();
        rd_req = 1'b1; rd_addr = 6'd0; cyc();
        rd_addr = 6'd1;
        chk("t1_a0_ack", rd_ack, 1); chk("t1_a0", rd_data, 10);
        cyc();
        rd_addr = 6'd2;
        chk("t1_a1_ack", rd_ack, 1); chk("t1_a1", rd_data, 0);
        cyc();
        rd_req = 1'b0;
        chk("t1_a2_ack", rd_ack, 1); chk("t1_a2", rd_data, 0);
        cyc();
        chk("t1_idle_ack", rd_ack, 0);

        // Attribution with flags 0x0006.
        pulse_clear();
        count_en = 1'b1; dispatch_stall = 1'b1; stall_flags = 16'h0006;
        repeat (4) cyc();
        count_en = 1'b0; dispatch_stall = 1'b0; stall_flags = '0;
        pulse_snap();
        rd(4, 4, "t2_prim1");
        rd(5, 0, "t2_prim2");
        rd(20, 4, "t2_raw1");
        rd(21, 4, "t2_raw2");
        rd(1, 4, "t2_stall");
        rd(2, 0, "t2_unattr");

        // Unattributed stalls, then stop into HOLD.
        pulse_clear();
        count_en = 1'b1; dispatch_stall = 1'b1;
        repeat (2) cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        repeat (5) cyc();
        count_en = 1'b0; dispatch_stall = 1'b0;
        chk("t3_state", state_o, 2);
        pulse_snap();
        rd(2, 3, "t3_unattr");
        rd(0, 3, "t3_total");

        // Atomic snapshot-and-clear.
        start = 1'b1; cyc(); start = 1'b0;
        pulse_clear();
        count_en = 1'b1;
        repeat (7) cyc();
        snap = 1'b1; clear = 1'b1; cyc(); snap = 1'b0; clear = 1'b0;
        repeat (2) cyc();
        count_en = 1'b0;
        rd(0, 7, "t4_first");
        pulse_snap();
        rd(0, 2, "t4_second");

        // Saturation on the 4-bit build.
        pulse_clear();
        count_en = 1'b1;
        repeat (20) cyc();
        count_en = 1'b0;
        chk("t5_ovf4", overflow4, 1);
        chk("t5_ovf", overflow, 0);
        pulse_snap();
        rd(0, 20, "t5_total");
        chk("t5_total4", rd_data4, 15);
        pulse_clear();
        chk("t5_ovf4_clr", overflow4, 0);
        pulse_snap();
        rd(0, 0, "t5_total_clr");
        chk("t5_total4_clr", rd_data4, 0);

        // Out-of-range read, then reset with a read pending.
        rd(63, 0, "t6_oor");
        count_en = 1'b1;
        repeat (3) cyc();
        count_en = 1'b0;
        pulse_snap();
        rd_req = 1'b1; rd_addr = 6'd0;
        #2 rst_n = 1'b0;
        cyc();
        chk("t6_rst_ack", rd_ack, 0);
        chk("t6_rst_data", rd_data, 0);
        chk("t6_rst_state", state_o, 0);
        chk("t6_rst_ovf4", overflow4, 0);
        rd_req = 1'b0;
        rst_n = 1'b1;
        rd(0, 0, "t6_shadow0");
        pulse_snap();
        rd(0, 0, "t6_live0");
        rd(20, 0, "t6_live20");

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            start          = ($urandom_range(0, 15) == 0);
            stop           = ($urandom_range(0, 31) == 0);
            count_en       = ($urandom_range(0, 7) != 0);
            dispatch_stall = ($urandom_range(0, 1) == 1);
            stall_flags    = ($urandom_range(0, 3) == 0) ? '0 : NC'($urandom & $urandom & $urandom);
            clear          = ($urandom_range(0, 63) == 0);
            snap           = ($urandom_range(0, 7) == 0);
            rd_req         = ($urandom_range(0, 1) == 1);
            rd_addr        = 6'($urandom_range(0, 63));
            cyc();
        end
        start = 1'b0; stop = 1'b0; count_en = 1'b0; clear = 1'b0; snap = 1'b0; rd_req = 1'b0;
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stall_perf_counter.md
Name: stall_perf_counter

Overview:
- Synthesizable downstream consumer of the core's per-cycle stall-condition flags: RS/SQ/LD-RS full, FU queues, mult/div busy, free-list empty, fetch-queue empty, ROB full and dispatch_stall.
- Accumulates total cycles, stall cycles, a priority-attributed primary cause per stalled cycle, and raw per-flag occurrence counts.
- Provides a snapshot shadow bank and a pipelined read port for a CSR/debug reader, replacing offline log post-processing.

Parameters:
- NUM_CAUSES, 16: width of stall_flags; bit 0 is highest attribution priority.
- CNT_W, 32: width of every counter.
- ADDR_W, 6: read address width; must satisfy 2^ADDR_W >= 3+2*NUM_CAUSES.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; enter RUN.
- stop  in  1  one-cycle pulse; enter HOLD.
- count_en  in  1  qualifies counting (low while core is flushing or not yet live).
- stall_flags  in  NUM_CAUSES  raw per-cycle stall conditions.
- dispatch_stall  in  1  dispatch did not advance this cycle.
- clear  in  1  synchronous pulse; zero live counters and overflow.
- snap  in  1  synchronous pulse; copy live counters into shadow bank.
- rd_req  in  1  read request.
- rd_addr  in  ADDR_W  shadow counter index.
- rd_ack  out  1  read data valid.
- rd_data  out  CNT_W  shadow counter value.
- overflow  out  1  sticky; some live counter saturated.
- state_o  out  2  FSM state: 0 IDLE, 1 RUN, 2 HOLD.

Behaviour:
- Reset (rst_n low, async): all live and shadow counters 0; rd_ack 0, rd_data 0, overflow 0, state IDLE.
- FSM transitions:
  - IDLE --start--> RUN.
  - RUN --stop--> HOLD.
  - HOLD --start--> RUN.
  - start and stop in the same cycle: stop wins.
  - clear does not change state.
- Counting occurs only when state==RUN and count_en==1 (a "counted cycle"). The transition cycle counts under the old state.
- Address map (live and shadow identical):
  - 0: total counted cycles.
  - 1: counted cycles with dispatch_stall.
  - 2: counted cycles with dispatch_stall and stall_flags==0 (unattributed).
  - 3..3+NUM_CAUSES-1: primary-cause counters. Increment index p = lowest set bit of stall_flags, only when dispatch_stall==1. Exactly one primary counter increments per attributed cycle.
  - 3+NUM_CAUSES..3+2*NUM_CAUSES-1: raw counters. Each counter whose flag is set increments every counted cycle, independent of dispatch_stall.
- Arithmetic: saturating at 2^CNT_W-1. An increment attempted at saturation holds the value and sets overflow. overflow is cleared only by clear or reset.
- clear: all live counters become 0 next edge; increments in that cycle are dropped; overflow cleared. Shadow bank is unaffected.
- snap: shadow takes live values as they were before this edge, excluding this cycle's increment.
- snap and clear in the same cycle: atomic snapshot-and-clear; shadow gets the pre-clear values, live goes to 0.
- Read path:
  - 1-cycle latency, fully pipelined: rd_req high in cycle N gives rd_ack=1 and rd_data in cycle N+1.
  - Back-to-back requests produce back-to-back acks.
  - rd_data reflects the shadow before any snap at edge N, so a same-cycle snap is not visible.
  - Out-of-range address: rd_ack=1, rd_data=0.
  - rd_ack=0 when no request; rd_data then holds its last value.
- Reset mid-operation: immediate return to the reset values above. No pending read ack survives reset.

Test Plan:
- Reset, start, count_en=1, 10 cycles with flags=0, dispatch_stall=0, snap, read addr 0,1,2 -> 10, 0, 0; acks on consecutive cycles.
- RUN, 4 cycles with dispatch_stall=1, stall_flags=0x0006, snap -> addr 3+1=4; addr 3+2 = 0; raw addr 3+16+1 = 4 and 3+16+2 = 4; addr 1 = 4.
- RUN, 3 cycles dispatch_stall=1, flags=0, then stop, 5 more stalled cycles, snap -> addr 2 = 3, addr 0 = 3; state_o = 2.
- snap and clear same cycle after 7 counted cycles, then 2 more cycles, snap -> first read of addr 0 = 7, second read after new snap = 2.
- CNT_W=4 build, 20 counted cycles -> addr 0 = 15, overflow=1; clear -> overflow=0, addr 0 = 0 after next snap.
- Read addr 63 -> rd_ack=1, rd_data=0. Assert rst_n low while rd_req pending -> rd_ack=0 next cycle, all counters 0, state IDLE.
